// File: rtl/pipeline_pkg.sv
// Shared pipeline types: access size encodings, word/register widths and
// lane helpers used by the memory stage.
package pipeline_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = off[0];
      default:   is_misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: lane_enable = 4'b0001 << off;
      SIZE_HALF: lane_enable = off[1] ? 4'b1100 : 4'b0011;
      default:   lane_enable = 4'b1111;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] lane_data(input logic [1:0] size, input logic [WORD_W-1:0] d);
    case (size)
      SIZE_BYTE: lane_data = {4{d[7:0]}};
      SIZE_HALF: lane_data = {2{d[15:0]}};
      default:   lane_data = d;
    endcase
  endfunction

endpackage

// File: rtl/data_ram_be.sv
// Single-port synchronous data RAM with per-byte write enables and a
// registered read port that holds its value while re is low.
module data_ram_be
  import pipeline_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic              re,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Contents survive reset; only the output register is cleared.
  always_ff @(posedge clock) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_wb_unit.sv
// Memory stage with built-in MEM/WB register. Define MEM_SUBWORD_EN to add
// byte/halfword loads and stores; otherwise every access is a word access.
module mem_wb_unit
  import pipeline_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [1:0]            ex_size,
  input  logic                  ex_unsigned,
  input  logic [WORD_W-1:0]     ex_alu_out,
  input  logic [WORD_W-1:0]     ex_store_data,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [WORD_W-1:0]     wb_data,
  output logic                  wb_misalign
);

  logic [1:0]        size_eff;
  logic [1:0]        off;
  logic              acc;
  logic              mem_op;
  logic              is_load;
  logic              mis;
  logic [3:0]        ram_we;
  logic              ram_re;
  logic [WORD_W-1:0] ram_q;
  logic [WORD_W-1:0] alu_q;
  logic              load_q;

`ifdef MEM_SUBWORD_EN
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        off_q;
  logic [WORD_W-1:0] ram_lane;

  assign size_eff = ex_size;
`else
  logic unused_cfg;

  assign unused_cfg = ^{ex_size, ex_unsigned};
  assign size_eff   = SIZE_WORD;
`endif

  assign off     = ex_alu_out[1:0];
  assign acc     = ex_valid & ~stall & ~flush;
  assign mem_op  = ex_mem_read | ex_mem_write;
  assign is_load = ex_mem_read & ~ex_mem_write;
  assign mis     = mem_op & is_misaligned(size_eff, off);
  assign ram_we  = (acc & ex_mem_write & ~mis & ~reset) ? lane_enable(size_eff, off) : 4'b0000;
  assign ram_re  = acc & is_load;

  data_ram_be #(.ADDR_W(ADDR_W)) u_ram (
    .clock (clock),
    .reset (reset),
    .addr  (ex_alu_out[ADDR_W+1:2]),
    .we    (ram_we),
    .re    (ram_re),
    .wdata (lane_data(size_eff, ex_store_data)),
    .rdata (ram_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_misalign  <= 1'b0;
      alu_q        <= '0;
      load_q       <= 1'b0;
`ifdef MEM_SUBWORD_EN
      size_q       <= SIZE_WORD;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
`endif
    end else if (flush) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_misalign  <= 1'b0;
    end else if (!stall) begin
      wb_valid     <= ex_valid;
      // Read+write together behaves as a store, so it never writes rd.
      wb_reg_write <= ex_valid & ex_reg_write & ~mis & ~(ex_mem_read & ex_mem_write);
      wb_rd        <= ex_rd;
      wb_misalign  <= ex_valid & mis;
      alu_q        <= ex_alu_out;
      load_q       <= ex_valid & is_load;
`ifdef MEM_SUBWORD_EN
      size_q       <= size_eff;
      uns_q        <= ex_unsigned;
      off_q        <= off;
`endif
    end
  end

`ifdef MEM_SUBWORD_EN
  assign ram_lane = ram_q >> {off_q, 3'b000};

  always_comb begin
    wb_data = alu_q;
    if (load_q) begin
      case (size_q)
        SIZE_BYTE: wb_data = uns_q ? {24'h0, ram_lane[7:0]}  : {{24{ram_lane[7]}}, ram_lane[7:0]};
        SIZE_HALF: wb_data = uns_q ? {16'h0, ram_lane[15:0]} : {{16{ram_lane[15]}}, ram_lane[15:0]};
        default:   wb_data = ram_q;
      endcase
    end
  end
`else
  assign wb_data = load_q ? ram_q : alu_q;
`endif

endmodule

// File: tb/tb_mem_wb_unit.sv
// Directed bench for mem_wb_unit: byte-addressed reference memory model
// compared every cycle, plus literal expectations on key results.
module tb_mem_wb_unit;

  localparam int ADDR_W = 8;
  localparam int MEM_BYTES = 4 << ADDR_W;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_unsigned, ex_reg_write;
  logic [1:0]  ex_size;
  logic [31:0] ex_alu_out, ex_store_data;
  logic [4:0]  ex_rd;
  logic        stall, flush;
  logic        wb_valid, wb_reg_write, wb_misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;

  mem_wb_unit #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_size(ex_size), .ex_unsigned(ex_unsigned),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .stall(stall), .flush(flush), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .wb_misalign(wb_misalign)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte memory plus expected write-back bundle.
  logic [7:0]  mem_m [MEM_BYTES];
  bit          wr_m  [MEM_BYTES];
  bit          m_live = 0;
  logic        e_valid, e_rw, e_mis;
  logic [4:0]  e_rd;
  logic [31:0] e_data;
  bit          e_known;
  int          m_n;
  logic [9:0]  m_a;
  logic [31:0] m_v;
  bit          m_mis, m_memop, m_uns;

  initial forever begin
    @(posedge clock);
    if (reset) begin
      m_live = 1; e_valid = 0; e_rw = 0; e_mis = 0; e_rd = 0; e_data = 0; e_known = 1;
    end else if (!m_live) begin
      // nothing to model before the first reset
    end else if (flush) begin
      e_valid = 0; e_rw = 0; e_mis = 0;
    end else if (!stall) begin
`ifdef MEM_SUBWORD_EN
      m_n   = (ex_size == 2'b00) ? 1 : (ex_size == 2'b01) ? 2 : 4;
      m_uns = ex_unsigned;
`else
      m_n   = 4;
      m_uns = 1;
`endif
      m_a     = ex_alu_out[9:0];
      m_memop = ex_mem_read | ex_mem_write;
      m_mis   = m_memop && ((int'(m_a) % m_n) != 0);
      e_valid = ex_valid;
      e_rd    = ex_rd;
      e_mis   = ex_valid & m_mis;
      e_rw    = ex_valid & ex_reg_write & !m_mis & !(ex_mem_read & ex_mem_write);
      e_data  = ex_alu_out;
      e_known = 1;
      if (ex_valid && ex_mem_write && !m_mis) begin
        for (int i = 0; i < m_n; i++) begin
          mem_m[10'(m_a + i)] = ex_store_data[8*i +: 8];
          wr_m[10'(m_a + i)]  = 1;
        end
      end else if (ex_valid && ex_mem_read && !ex_mem_write && !m_mis) begin
        m_v = 0;
        for (int i = 0; i < m_n; i++) begin
          m_v[8*i +: 8] = mem_m[10'(m_a + i)];
          if (!wr_m[10'(m_a + i)]) e_known = 0;
        end
        if (m_n == 1 && !m_uns) m_v = {{24{m_v[7]}}, m_v[7:0]};
        if (m_n == 2 && !m_uns) m_v = {{16{m_v[15]}}, m_v[15:0]};
        e_data = m_v;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (m_live) begin
      chk("cyc_valid", {31'b0, wb_valid}, {31'b0, e_valid});
      chk("cyc_reg_write", {31'b0, wb_reg_write}, {31'b0, e_rw});
      chk("cyc_misalign", {31'b0, wb_misalign}, {31'b0, e_mis});
      if (e_valid) chk("cyc_rd", {27'b0, wb_rd}, {27'b0, e_rd});
      if (e_valid && !e_mis && e_known) chk("cyc_data", wb_data, e_data);
    end
  end

  task automatic put(input logic v, mr, mw, input logic [1:0] sz, input logic un,
                     input logic [31:0] a, sd, input logic rw, input logic [4:0] rd,
                     input logic st, fl, rs);
    ex_valid = v; ex_mem_read = mr; ex_mem_write = mw; ex_size = sz; ex_unsigned = un;
    ex_alu_out = a; ex_store_data = sd; ex_reg_write = rw; ex_rd = rd;
    stall = st; flush = fl; reset = rs;
    @(posedge clock);
    #1;
  endtask

  task automatic sw_(input logic [31:0] a, d);
    put(1, 0, 1, 2'b10, 0, a, d, 0, 5'd0, 0, 0, 0);
  endtask
  task automatic lw_(input logic [31:0] a, input logic [4:0] rd);
    put(1, 1, 0, 2'b10, 0, a, 32'h0, 1, rd, 0, 0, 0);
  endtask
  task automatic st_(input logic [1:0] sz, input logic [31:0] a, d);
    put(1, 0, 1, sz, 0, a, d, 0, 5'd0, 0, 0, 0);
  endtask
  task automatic ld_(input logic [1:0] sz, input logic un, input logic [31:0] a, input logic [4:0] rd);
    put(1, 1, 0, sz, un, a, 32'h0, 1, rd, 0, 0, 0);
  endtask
  task automatic bubble();
    put(0, 0, 0, 2'b10, 0, 32'h0, 32'h0, 0, 5'd0, 0, 0, 0);
  endtask

  logic [31:0] w10, w14;

  initial begin
`ifdef MEM_SUBWORD_EN
    w10 = 32'h80ADBEEF; w14 = 32'h56783344;
`else
    w10 = 32'hDEADBEEF; w14 = 32'h11223344;
`endif
    put(0, 0, 0, 2'b10, 0, 32'h0, 32'h0, 0, 5'd0, 0, 0, 1);
    put(0, 0, 0, 2'b10, 0, 32'h0, 32'h0, 0, 5'd0, 0, 0, 1);
    chk("rst_valid", {31'b0, wb_valid}, 32'h0);
    chk("rst_reg_write", {31'b0, wb_reg_write}, 32'h0);
    chk("rst_rd", {27'b0, wb_rd}, 32'h0);
    chk("rst_data", wb_data, 32'h0);
    chk("rst_misalign", {31'b0, wb_misalign}, 32'h0);

    sw_(32'h10, 32'hDEADBEEF);
    lw_(32'h10, 5'd5);
    chk("lw_data", wb_data, 32'hDEADBEEF);
    chk("lw_rd", {27'b0, wb_rd}, 32'd5);
    chk("lw_reg_write", {31'b0, wb_reg_write}, 32'd1);

    st_(2'b00, 32'h13, 32'h00000080);
    ld_(2'b00, 0, 32'h13, 5'd6);
`ifdef MEM_SUBWORD_EN
    chk("lb_data", wb_data, 32'hFFFFFF80);
`endif
    ld_(2'b00, 1, 32'h13, 5'd7);
`ifdef MEM_SUBWORD_EN
    chk("lbu_data", wb_data, 32'h00000080);
`endif
    lw_(32'h10, 5'd8);
    chk("sb_word", wb_data, w10);
    ld_(2'b01, 0, 32'h12, 5'd9);
`ifdef MEM_SUBWORD_EN
    chk("lh_data", wb_data, 32'hFFFF80AD);
`endif
    sw_(32'h14, 32'h11223344);
    st_(2'b01, 32'h16, 32'hAAAA5678);
    ld_(2'b01, 1, 32'h16, 5'd10);
`ifdef MEM_SUBWORD_EN
    chk("lhu_data", wb_data, 32'h00005678);
`endif
    lw_(32'h14, 5'd11);
    chk("sh_word", wb_data, w14);

    lw_(32'h12, 5'd12);
    chk("mis_flag", {31'b0, wb_misalign}, 32'd1);
    chk("mis_reg_write", {31'b0, wb_reg_write}, 32'd0);
    chk("mis_valid", {31'b0, wb_valid}, 32'd1);
    sw_(32'h11, 32'hFFFFFFFF);
    lw_(32'h10, 5'd13);
    chk("mis_sw_nowrite", wb_data, w10);

    lw_(32'h14, 5'd14);
    for (int i = 0; i < 3; i++) begin
      put(1, 0, 1, 2'b10, 0, 32'h14, 32'h0, 0, 5'd0, 1, 0, 0);
      chk("stall_data", wb_data, w14);
      chk("stall_rd", {27'b0, wb_rd}, 32'd14);
    end
    put(1, 0, 1, 2'b10, 0, 32'h14, 32'h55555555, 0, 5'd0, 1, 1, 0);
    chk("flush_valid", {31'b0, wb_valid}, 32'd0);
    lw_(32'h14, 5'd15);
    chk("flush_nowrite", wb_data, w14);

    sw_(32'h400, 32'h1);
    lw_(32'h0, 5'd16);
    chk("wrap_data", wb_data, 32'h1);

    put(1, 0, 0, 2'b10, 0, 32'h12345677, 32'h0, 1, 5'd17, 0, 0, 0);
    chk("alu_data", wb_data, 32'h12345677);
    chk("alu_misalign", {31'b0, wb_misalign}, 32'd0);
    bubble();
    chk("bubble_valid", {31'b0, wb_valid}, 32'd0);

    put(1, 1, 1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 1, 5'd18, 0, 0, 0);
    chk("rw_both_reg_write", {31'b0, wb_reg_write}, 32'd0);
    lw_(32'h20, 5'd19);
    chk("rw_both_store", wb_data, 32'hCAFEF00D);

    lw_(32'h0, 5'd20);
    put(1, 1, 0, 2'b10, 0, 32'h0, 32'h0, 1, 5'd20, 1, 0, 1);
    chk("mid_rst_valid", {31'b0, wb_valid}, 32'h0);
    chk("mid_rst_data", wb_data, 32'h0);
    chk("mid_rst_rd", {27'b0, wb_rd}, 32'h0);
    lw_(32'h0, 5'd21);
    chk("ram_keeps", wb_data, 32'h1);

    bubble();
    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
